// File: rtl/wshb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } grant_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam int unsigned SEL_W = 4;

    // Round-robin pick: on a tie the master that was not served last wins.
    function automatic grant_t rr_pick(input logic [1:0] req, input logic last);
        grant_t g;
        case (req)
            2'b01:   g = G0;
            2'b10:   g = G1;
            2'b11:   g = last ? G0 : G1;
            default: g = IDLE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wshb_arbiter_watchdog.sv
// Per-access watchdog: counts stalled strobe cycles and raises a one-cycle abort.
module wshb_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic done,
    input  logic restart,
    output logic abort
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 2);

    logic [CNT_W-1:0] count_q;

    // Abort is flagged for the cycle in which the count sits at TIMEOUT-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            abort   <= 1'b0;
        end else begin
            abort <= 1'b0;
            if (restart || done || abort) begin
                count_q <= '0;
            end else if (active) begin
                count_q <= count_q + CNT_W'(1);
                if (count_q == LAST) begin
                    abort <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master round-robin Wishbone arbiter with cycle-held grant and access watchdog.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                    wshb_clk,
    input  logic                    wshb_rst_n,
    input  logic [1:0]              m_cyc,
    input  logic [1:0]              m_stb,
    input  logic [1:0]              m_we,
    input  logic [2*ADDR_W-1:0]     m_adr,
    input  logic [2*DATA_W-1:0]     m_dat_w,
    input  logic [2*(DATA_W/8)-1:0] m_sel,
    input  logic [5:0]              m_cti,
    input  logic [3:0]              m_bte,
    output logic [DATA_W-1:0]       m_dat_r,
    output logic [1:0]              m_ack,
    output logic [1:0]              m_err,
    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [ADDR_W-1:0]       s_adr,
    output logic [DATA_W-1:0]       s_dat_w,
    output logic [DATA_W/8-1:0]     s_sel,
    output logic [2:0]              s_cti,
    output logic [1:0]              s_bte,
    input  logic [DATA_W-1:0]       s_dat_r,
    input  logic                    s_ack,
    input  logic                    s_err,
    output logic [1:0]              grant,
    output logic                    timeout_evt
);

    localparam int unsigned SW = DATA_W / 8;

    grant_t grant_q, grant_d;
    logic   last_q, last_d;
    logic   abort;
    logic   idx;
    logic   granted;

    assign grant   = grant_q;
    assign idx     = (grant_q == G1);
    assign granted = (grant_q != IDLE);
    assign m_dat_r = s_dat_r;
    assign timeout_evt = abort;

    // Grant / last-served register.
    always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
        if (!wshb_rst_n) begin
            grant_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Hold grant for the whole cycle; abort drops to IDLE, release re-arbitrates at once.
    always_comb begin
        grant_d = grant_q;
        last_d  = last_q;
        case (grant_q)
            G0: begin
                if (abort) begin
                    grant_d = IDLE;
                    last_d  = 1'b0;
                end else if (!m_cyc[0]) begin
                    last_d  = 1'b0;
                    grant_d = rr_pick(m_cyc, 1'b0);
                end
            end
            G1: begin
                if (abort) begin
                    grant_d = IDLE;
                    last_d  = 1'b1;
                end else if (!m_cyc[1]) begin
                    last_d  = 1'b1;
                    grant_d = rr_pick(m_cyc, 1'b1);
                end
            end
            default: grant_d = rr_pick(m_cyc, last_q);
        endcase
    end

    // Slave-side mux and master-side response steering from the registered grant.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_cti   = '0;
        s_bte   = '0;
        m_ack   = '0;
        m_err   = '0;
        if (granted) begin
            s_cyc      = m_cyc[idx] & ~abort;
            s_stb      = m_stb[idx] & ~abort;
            s_we       = m_we[idx];
            s_adr      = idx ? m_adr[ADDR_W +: ADDR_W]   : m_adr[0 +: ADDR_W];
            s_dat_w    = idx ? m_dat_w[DATA_W +: DATA_W] : m_dat_w[0 +: DATA_W];
            s_sel      = idx ? m_sel[SW +: SW]           : m_sel[0 +: SW];
            s_cti      = idx ? m_cti[3 +: 3]             : m_cti[0 +: 3];
            s_bte      = idx ? m_bte[2 +: 2]             : m_bte[0 +: 2];
            m_ack[idx] = s_ack & ~abort;
            m_err[idx] = s_err | abort;
        end
    end

    wshb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (wshb_clk),
        .rst_n   (wshb_rst_n),
        .active  (s_cyc & s_stb),
        .done    (s_ack | s_err),
        .restart (grant_d != grant_q),
        .abort   (abort)
    );

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed self-checking bench for wshb_arbiter (TIMEOUT = 8).
module tb_wshb_arbiter;
    import wshb_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [63:0] m_adr, m_dat_w;
    logic [2*SEL_W-1:0] m_sel;
    logic [5:0]  m_cti;
    logic [3:0]  m_bte;
    logic [31:0] m_dat_r;
    logic [1:0]  m_ack, m_err;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_w, s_dat_r;
    logic [SEL_W-1:0] s_sel;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;
    logic        s_ack, s_err;
    logic [1:0]  grant;
    logic        timeout_evt;

    int vecs = 0;
    int errs = 0;
    int acks0, acks1;

    wshb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .wshb_clk(clk), .wshb_rst_n(rst_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
        .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_w(s_dat_w), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
        .grant(grant), .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_s_cyc", 64'(s_cyc), 64'h0);
        chk("rst_s_stb", 64'(s_stb), 64'h0);
        chk("rst_s_adr", 64'(s_adr), 64'h0);
        chk("rst_m_ack", 64'(m_ack), 64'h0);
        chk("rst_m_err", 64'(m_err), 64'h0);
        chk("rst_tevt",  64'(timeout_evt), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0;
        m_sel = '0; m_cti = '0; m_bte = '0; s_dat_r = '0; s_ack = 1'b0; s_err = 1'b0;
        do_reset();

        // Master 0 alone: 16-beat INCR read, slave acks every cycle.
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
        m_adr[31:0] = 32'h1000; m_sel[3:0] = 4'hF; m_cti[2:0] = CTI_INCR; m_bte[1:0] = 2'b00;
        #1;
        chk("t1_lat_s_cyc", 64'(s_cyc), 64'h0);
        chk("t1_lat_grant", 64'(grant), 64'h0);
        acks0 = 0; acks1 = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            m_adr[31:0] = 32'h1000 + 32'(4 * i);
            m_cti[2:0]  = (i == 15) ? CTI_END : CTI_INCR;
            s_ack = 1'b1;
            s_dat_r = 32'hA500 + 32'(i);
            #1;
            if (i == 0) begin
                chk("t1_grant", 64'(grant), 64'h1);
                chk("t1_s_cyc", 64'(s_cyc), 64'h1);
                chk("t1_s_cti", 64'(s_cti), 64'(CTI_INCR));
                chk("t1_s_sel", 64'(s_sel), 64'hF);
                chk("t1_s_bte", 64'(s_bte), 64'h0);
            end
            chk("t1_s_adr", 64'(s_adr), 64'(32'h1000 + 32'(4 * i)));
            chk("t1_dat_r", 64'(m_dat_r), 64'(32'hA500 + 32'(i)));
            if (m_ack[0]) acks0++;
            if (m_ack[1]) acks1++;
        end
        tick();
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
        #1;
        chk("t1_ack0_count", 64'(acks0), 64'd16);
        chk("t1_ack1_count", 64'(acks1), 64'd0);
        chk("t1_hold_grant", 64'(grant), 64'h1);
        chk("t1_rel_s_cyc", 64'(s_cyc), 64'h0);
        tick();
        chk("t1_idle", 64'(grant), 64'h0);

        // Tie right after reset, then direct handover, then a second tie.
        do_reset();
        tick();
        m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b10;
        m_adr = {32'h0000_00B0, 32'h0000_00A0}; m_dat_w = {32'hDEAD_BEEF, 32'h0};
        #1;
        chk("t2_pre_grant", 64'(grant), 64'h0);
        tick();
        s_ack = 1'b1;
        #1;
        chk("t2_tie1_grant", 64'(grant), 64'h1);
        chk("t2_tie1_adr", 64'(s_adr), 64'hA0);
        chk("t2_tie1_ack", 64'(m_ack), 64'h1);
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b0;
        #1;
        chk("t2_rel_grant", 64'(grant), 64'h1);
        tick();
        s_ack = 1'b1;
        #1;
        chk("t2_handover", 64'(grant), 64'h2);
        chk("t2_g1_s_cyc", 64'(s_cyc), 64'h1);
        chk("t2_g1_adr", 64'(s_adr), 64'hB0);
        chk("t2_g1_we", 64'(s_we), 64'h1);
        chk("t2_g1_dat_w", 64'(s_dat_w), 64'hDEAD_BEEF);
        chk("t2_g1_ack", 64'(m_ack), 64'h2);
        tick();
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
        tick();
        chk("t2_idle", 64'(grant), 64'h0);
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        chk("t2_tie2_grant", 64'(grant), 64'h1);
        m_cyc = '0; m_stb = '0;
        tick();
        chk("t2_idle2", 64'(grant), 64'h0);

        // Master 1 continuous write; master 0 requests mid-cycle and must wait.
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we = 2'b10; m_adr[63:32] = 32'h200;
        for (int j = 0; j < 4; j++) begin
            tick();
            m_adr[63:32] = 32'h200 + 32'(4 * j);
            s_ack = 1'b1;
            if (j == 1) begin
                m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[31:0] = 32'h300;
            end
            #1;
            chk("t3_hold_grant", 64'(grant), 64'h2);
            chk("t3_m_ack", 64'(m_ack), 64'h2);
            chk("t3_s_adr", 64'(s_adr), 64'(32'h200 + 32'(4 * j)));
        end
        tick();
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b0;
        #1;
        chk("t3_rel_grant", 64'(grant), 64'h2);
        tick();
        s_ack = 1'b1;
        #1;
        chk("t3_switch", 64'(grant), 64'h1);
        chk("t3_m0_adr", 64'(s_adr), 64'h300);
        chk("t3_m0_ack", 64'(m_ack), 64'h1);
        tick();
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
        tick();
        chk("t3_idle", 64'(grant), 64'h0);

        // Silent slave: master 1 is aborted in the eighth strobed cycle.
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we = 2'b10; m_adr[63:32] = 32'h400;
        for (int c = 1; c <= 7; c++) begin
            tick();
            #1;
            chk("t4_wait_s_cyc", 64'(s_cyc), 64'h1);
            chk("t4_wait_err", 64'(m_err), 64'h0);
            chk("t4_wait_tevt", 64'(timeout_evt), 64'h0);
        end
        tick();
        chk("t4_abort_s_cyc", 64'(s_cyc), 64'h0);
        chk("t4_abort_s_stb", 64'(s_stb), 64'h0);
        chk("t4_abort_err", 64'(m_err), 64'h2);
        chk("t4_abort_tevt", 64'(timeout_evt), 64'h1);
        chk("t4_abort_grant", 64'(grant), 64'h2);
        m_cyc = '0; m_stb = '0;
        tick();
        s_ack = 1'b1;
        #1;
        chk("t4_late_ack", 64'(m_ack), 64'h0);
        chk("t4_post_err", 64'(m_err), 64'h0);
        chk("t4_post_tevt", 64'(timeout_evt), 64'h0);
        chk("t4_post_grant", 64'(grant), 64'h0);
        s_ack = 1'b0;

        // Ack lands on the terminal count: ack wins, no abort.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we = 2'b00; m_adr[31:0] = 32'h600;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 7) s_ack = 1'b1;
            #1;
            chk("t5_wait_err", 64'(m_err), 64'h0);
            chk("t5_wait_tevt", 64'(timeout_evt), 64'h0);
            if (c == 7) chk("t5_term_ack", 64'(m_ack), 64'h1);
        end
        tick();
        s_ack = 1'b0;
        #1;
        chk("t5_no_tevt", 64'(timeout_evt), 64'h0);
        chk("t5_no_err", 64'(m_err), 64'h0);
        chk("t5_still_cyc", 64'(s_cyc), 64'h1);
        m_cyc = '0; m_stb = '0;
        tick();
        chk("t5_idle", 64'(grant), 64'h0);

        // Reset in the middle of a granted burst.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[31:0] = 32'h500;
        tick();
        s_ack = 1'b1;
        #1;
        chk("t6_pre_ack", 64'(m_ack), 64'h1);
        chk("t6_pre_s_cyc", 64'(s_cyc), 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_s_cyc", 64'(s_cyc), 64'h0);
        chk("t6_rst_grant", 64'(grant), 64'h0);
        chk("t6_rst_ack", 64'(m_ack), 64'h0);
        m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_tie_after_rst", 64'(grant), 64'h1);
        m_cyc = '0; m_stb = '0;
        tick();
        chk("t6_idle", 64'(grant), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/wshb_arbiter.md
Name: wshb_arbiter

Overview:
- Two-master, one-slave Wishbone B4 (classic/registered-feedback) arbiter feeding the SDRAM controller port of the video Top.
- Master 0 is the VGA framebuffer reader (read bursts filling the pixel FIFO). Master 1 is the mire/pattern writer.
- Round-robin grant held for the whole Wishbone cycle (cyc high), plus a per-access watchdog so a silent slave cannot freeze the display path.

Parameters:
- ADDR_W, 32, Wishbone address width (byte address).
- DATA_W, 32, Wishbone data width; SEL width = DATA_W/8.
- TIMEOUT, 1024, clock cycles a strobed access may wait for ack/err before the arbiter aborts it (>= 2).

Ports:
- wshb_clk  in  1  Wishbone clock, same as sys_clk.
- wshb_rst_n  in  1  asynchronous active-low reset.
- m_cyc  in  2  cyc per master, bit i = master i.
- m_stb  in  2  stb per master.
- m_we  in  2  write enable per master.
- m_adr  in  2*ADDR_W  address per master, master i at [i*ADDR_W +: ADDR_W].
- m_dat_w  in  2*DATA_W  write data per master.
- m_sel  in  2*DATA_W/8  byte selects per master.
- m_cti  in  2*3  cycle type per master.
- m_bte  in  2*2  burst type per master.
- m_dat_r  out  DATA_W  slave read data, broadcast to both masters.
- m_ack  out  2  ack per master.
- m_err  out  2  err per master.
- s_cyc, s_stb, s_we  out  1 each  to slave.
- s_adr  out  ADDR_W.
- s_dat_w  out  DATA_W.
- s_sel  out  DATA_W/8.
- s_cti  out  3.
- s_bte  out  2.
- s_dat_r  in  DATA_W.
- s_ack, s_err  in  1 each.
- grant  out  2  registered one-hot grant; 00 = idle.
- timeout_evt  out  1  one-cycle pulse when an access is aborted.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - grant = 00, last-served pointer = 1 so master 0 wins the first tie.
  - Watchdog count = 0, timeout_evt = 0.
  - All s_* outputs and m_ack/m_err = 0.
- States, held in the grant register: IDLE (00), G0 (01), G1 (10).
- Transitions, evaluated each rising edge:
  - IDLE: if exactly one m_cyc is high -> grant that master. If both -> grant the master not equal to last-served.
  - Gi while m_cyc[i] high: stay in Gi.
  - Gi when m_cyc[i] is low at the edge: re-arbitrate immediately with the IDLE rule (direct handover G0->G1 possible in one edge). last-served = i.
  - Abort (see watchdog) also forces re-arbitration on the next edge, with last-served = i.
- Datapath is combinational from the registered grant:
  - s_cyc = m_cyc[g] and s_stb = m_stb[g] when granted, else 0.
  - Address, data, sel, we, cti and bte are muxed from master g.
  - m_ack[g] = s_ack; m_err[g] = s_err or abort pulse. The non-granted master sees ack = err = 0.
- Arbitration latency: 1 cycle from m_cyc rise (idle arbiter) to s_cyc high. Zero added latency on ack/data.
- Watchdog:
  - Counter increments while s_cyc & s_stb & !s_ack & !s_err.
  - Clears on ack, err, or grant change.
  - When it reaches TIMEOUT-1, the next cycle drives m_err[g] = 1, forces s_cyc = s_stb = 0, pulses timeout_evt, and the grant drops to IDLE at the following edge.
  - A late s_ack arriving after an abort is ignored (grant already changed).
- Simultaneous events:
  - Ack and counter terminal in the same cycle: ack wins, no abort.
  - Both masters raise cyc in the same cycle: round-robin decides.
- Reset mid-burst: outputs drop asynchronously; the slave must tolerate a truncated cycle.

Decomposition:
- Package wshb_arb_pkg: grant_t enum {IDLE, G0, G1}, CTI constants (CLASSIC = 3'b000, INCR = 3'b010, END = 3'b111), localparam SEL_W.
- One natural sub-module: wshb_watchdog (counter + abort pulse, parameter TIMEOUT).

Test Plan:
- Only master 0 issues a 16-beat INCR read with slave ack every cycle -> s_cyc high one cycle after m_cyc[0]; grant = 01; 16 m_ack[0] pulses; m_ack[1] stays 0; grant = 00 one edge after m_cyc[0] falls.
- Both masters raise cyc at the same edge after reset -> grant = 01 first. After master 0 releases -> grant = 10 with no idle cycle. Next tie -> 01.
- Master 1 continuous write, master 0 requests mid-cycle -> master 1 keeps the grant until its cyc drops. Master 0 gets the grant at that edge; its first s_adr equals m_adr[0].
- Slave never acks, TIMEOUT = 8 -> m_err[1] pulses on cycle 8 after stb; timeout_evt = 1 for one cycle; s_cyc = 0; grant returns to 00.
- Assert wshb_rst_n low during a granted burst -> s_cyc, grant and m_ack are 0 immediately (asynchronous). After release, a tie goes to master 0.
